// File: rtl/std_mult_pipe_pkg.sv
// Shared types and constants for the multi-cycle multiplier.
package std_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Largest supported pipeline depth
    localparam int MAX_STAGES = 8;

    // Counter wide enough to hold any value up to MAX_STAGES
    localparam int CNT_W = $clog2(MAX_STAGES) + 1;

endpackage

// File: rtl/std_mult_pipe_ctrl.sv
// Control FSM for std_mult_pipe: sequences IDLE -> BUSY -> DONE and emits
// accept/advance/done strobes for the datapath.
module std_mult_pipe_ctrl
    import std_pkg::*;
#(
    parameter int stages = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    output logic accept_o,
    output logic advance_o,
    output logic done_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_s;

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter tracks how many BUSY cycles have elapsed
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    accept_s = 1'b1;
                    if (stages == 1) begin
                        state_d = DONE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(stages - 1)) begin
                    state_d = DONE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign accept_o  = accept_s;
    assign advance_o = (state_q == BUSY);
    assign done_o    = (state_q == DONE);

endmodule

// File: rtl/std_mult_pipe.sv
// Fixed-latency unsigned multiplier: operands latched on accept, product
// carried through a shift pipeline, result and ready pulse registered.
module std_mult_pipe
    import std_pkg::*;
#(
    parameter int width  = 32,
    parameter int stages = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out,
    output logic             ready
);

    logic             accept_s, advance_s, done_s;
    logic [width-1:0] a_q, b_q;
    logic [width-1:0] prod_s;
    logic [width-1:0] final_s;
    logic [width-1:0] out_q;
    logic             ready_q;

    std_mult_pipe_ctrl #(.stages(stages)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid),
        .accept_o  (accept_s),
        .advance_o (advance_s),
        .done_o    (done_s)
    );

    // Operand latch; operands are frozen for the whole operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= {width{1'b0}};
            b_q <= {width{1'b0}};
        end else if (accept_s) begin
            a_q <= left;
            b_q <= right;
        end else begin
            a_q <= a_q;
            b_q <= b_q;
        end
    end

    // Self-determined width keeps only the low product bits (mod 2^width)
    assign prod_s = a_q * b_q;

    generate
        if (stages > 1) begin : g_pipe
            logic [width-1:0] pipe_q [stages-1];

            // Product shift pipeline, moves only while the controller is BUSY
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < stages - 1; i++) begin
                        pipe_q[i] <= {width{1'b0}};
                    end
                end else if (advance_s) begin
                    pipe_q[0] <= prod_s;
                    for (int i = 1; i < stages - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end else begin
                    for (int i = 0; i < stages - 1; i++) begin
                        pipe_q[i] <= pipe_q[i];
                    end
                end
            end

            assign final_s = pipe_q[stages-2];
        end else begin : g_direct
            assign final_s = prod_s;
        end
    endgenerate

    // Output register: result captured together with the one-cycle ready pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= {width{1'b0}};
            ready_q <= 1'b0;
        end else begin
            ready_q <= done_s;
            if (done_s) begin
                out_q <= final_s;
            end else begin
                out_q <= out_q;
            end
        end
    end

    assign out   = out_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_std_mult_pipe.sv
// Self-checking bench for std_mult_pipe (32-bit/3-stage, 8-bit/3-stage,
// 32-bit/1-stage instances).
module tb_std_mult_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v32 = 1'b0, v8 = 1'b0, v1 = 1'b0;
    logic [31:0] l32 = 32'd0, r32 = 32'd0, o32;
    logic [7:0]  l8 = 8'd0, r8 = 8'd0, o8;
    logic [31:0] l1 = 32'd0, r1 = 32'd0, o1;
    logic        rd32, rd8, rd1;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    std_mult_pipe #(.width(32), .stages(3)) dut32 (
        .clk(clk), .reset(reset), .valid(v32), .left(l32), .right(r32),
        .out(o32), .ready(rd32));

    std_mult_pipe #(.width(8), .stages(3)) dut8 (
        .clk(clk), .reset(reset), .valid(v8), .left(l8), .right(r8),
        .out(o8), .ready(rd8));

    std_mult_pipe #(.width(32), .stages(1)) dut1 (
        .clk(clk), .reset(reset), .valid(v1), .left(l1), .right(r1),
        .out(o1), .ready(rd1));

    // Reference model: unsigned product reduced modulo 2^w
    function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return 32'(p % 64'h1_0000_0000);
    endfunction

    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return 8'(p % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_run++;
        if ({rd32, rd8, rd1} !== 3'b000 || {o32, o8, o1} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_hold ready=%b out=%h/%h/%h want 0", {rd32, rd8, rd1}, o32, o8, o1);
        end
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_run++;
            if ({rd32, rd8, rd1} !== 3'b000 || {o32, o8, o1} !== 72'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d ready=%b out=%h/%h/%h want 0", k, {rd32, rd8, rd1}, o32, o8, o1);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        l32 = 32'd7; r32 = 32'd6; v32 = 1'b1;
        tick();
        v32 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = (k >= 3) ? 32'd42 : 32'd0;
            n_run++;
            if (rd32 !== (k == 3)) begin
                n_fail++;
                $display("FAIL basic_ready edge=%0d got %b want %b", k, rd32, (k == 3));
            end
            n_run++;
            if (o32 !== exp) begin
                n_fail++;
                $display("FAIL basic_out edge=%0d got %0d want %0d", k, o32, exp);
            end
        end
    endtask

    task automatic test_truncation();
        logic [7:0] la [2] = '{8'hFF, 8'd16};
        logic [7:0] ra [2] = '{8'h02, 8'd16};
        logic [7:0] ea [2] = '{8'hFE, 8'h00};
        for (int t = 0; t < 2; t++) begin
            l8 = la[t]; r8 = ra[t]; v8 = 1'b1;
            tick();
            v8 = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                n_run++;
                if (rd8 !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL trunc_ready op=%0d edge=%0d got %b want %b", t, k, rd8, (k == 3));
                end
                if (k == 3) begin
                    n_run++;
                    if (o8 !== ea[t]) begin
                        n_fail++;
                        $display("FAIL trunc_out op=%0d got %h want %h", t, o8, ea[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_operand_change();
        l32 = 32'd3; r32 = 32'd5; v32 = 1'b1;
        tick();
        l32 = 32'd9; r32 = 32'd9;
        tick();
        v32 = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            tick();
            n_run++;
            if (rd32 !== (k == 3)) begin
                n_fail++;
                $display("FAIL change_ready edge=%0d got %b want %b", k, rd32, (k == 3));
            end
            if (k >= 3) begin
                n_run++;
                if (o32 !== 32'd15) begin
                    n_fail++;
                    $display("FAIL change_out edge=%0d got %0d want 15", k, o32);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        l32 = 32'd2; r32 = 32'd3; v32 = 1'b1;
        tick();
        l32 = 32'd4; r32 = 32'd5;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 4) v32 = 1'b0;
            if (rd32 === 1'b1) pulses++;
            n_run++;
            if (rd32 !== (k == 3 || k == 7)) begin
                n_fail++;
                $display("FAIL b2b_ready edge=%0d got %b want %b", k, rd32, (k == 3 || k == 7));
            end
            if (k >= 3) begin
                n_run++;
                if (o32 !== ((k >= 7) ? 32'd20 : 32'd6)) begin
                    n_fail++;
                    $display("FAIL b2b_out edge=%0d got %0d want %0d", k, o32, (k >= 7) ? 20 : 6);
                end
            end
        end
        n_run++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses got %0d want 2", pulses);
        end
    endtask

    task automatic test_async_reset();
        l32 = 32'd11; r32 = 32'd11; v32 = 1'b1;
        tick();
        v32 = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_run++;
        if (o32 !== 32'd0 || rd32 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset out=%0d ready=%b want 0/0", o32, rd32);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_run++;
            if (rd32 !== 1'b0 || o32 !== 32'd0) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d ready=%b out=%0d want 0/0", k, rd32, o32);
            end
        end
        l32 = 32'd10; r32 = 32'd10; v32 = 1'b1;
        tick();
        v32 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_run++;
            if (rd32 !== (k == 3)) begin
                n_fail++;
                $display("FAIL reop_ready edge=%0d got %b want %b", k, rd32, (k == 3));
            end
        end
        n_run++;
        if (o32 !== 32'd100) begin
            n_fail++;
            $display("FAIL reop_out got %0d want 100", o32);
        end
    endtask

    task automatic test_stages1();
        l1 = 32'd4; r1 = 32'd4; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_run++;
            if (rd1 !== (k == 1)) begin
                n_fail++;
                $display("FAIL s1_ready edge=%0d got %b want %b", k, rd1, (k == 1));
            end
            n_run++;
            if (o1 !== 32'd16) begin
                n_fail++;
                $display("FAIL s1_out edge=%0d got %0d want 16", k, o1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a32, b32, a1, b1, e32, e1;
        logic [7:0]  a8, b8, e8;
        for (int it = 0; it < 30; it++) begin
            a32 = $urandom; b32 = $urandom;
            a1  = $urandom; b1  = $urandom;
            a8  = 8'($urandom); b8 = 8'($urandom);
            e32 = ref32(a32, b32); e1 = ref32(a1, b1); e8 = ref8(a8, b8);
            l32 = a32; r32 = b32; v32 = 1'b1;
            l8  = a8;  r8  = b8;  v8  = 1'b1;
            l1  = a1;  r1  = b1;  v1  = 1'b1;
            tick();
            v1 = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                l32 = $urandom; r32 = $urandom;
                l8 = 8'($urandom); r8 = 8'($urandom);
                l1 = $urandom; r1 = $urandom;
                v32 = (k < 3) ? 1'($urandom) : 1'b0;
                v8  = (k < 3) ? 1'($urandom) : 1'b0;
                tick();
                n_run++;
                if ({rd32, rd8, rd1} !== {(k == 3), (k == 3), (k == 1)}) begin
                    n_fail++;
                    $display("FAIL rand_ready it=%0d edge=%0d got %b want %b", it, k,
                             {rd32, rd8, rd1}, {(k == 3), (k == 3), (k == 1)});
                end
                if (k == 1) begin
                    n_run++;
                    if (o1 !== e1) begin
                        n_fail++;
                        $display("FAIL rand_s1 it=%0d got %h want %h", it, o1, e1);
                    end
                end
                if (k == 3) begin
                    n_run++;
                    if (o32 !== e32 || o8 !== e8) begin
                        n_fail++;
                        $display("FAIL rand_out it=%0d got %h/%h want %h/%h", it, o32, o8, e32, e8);
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_operand_change();
        test_back_to_back();
        test_async_reset();
        test_stages1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
